i2cmb_wb_responder: RTL and testbench

Behavioural Wishbone responder that models the I2CMB register interface: the CSR, DPR, CMDR and FSMR registers. It runs a fixed-latency byte-level command engine and raises an interrupt on command completion. It sits on the slave end of the wb agent inside the i2cmb environment. It lets the wb driver, the predictor and the CMDR assertions run without the full controller RTL.

---
 rtl/i2cmb_wb_responder.sv | 199 +++++++++++++++++++
 tb/tb_i2cmb_wb_responder.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/i2cmb_wb_responder.sv
`timescale 1ns/1ps
// ----------------------------------------------------------------------------
// i2cmb_wb_responder
//
// Behavioural Wishbone slave that stands in for the I2CMB controller. It
// exposes the CSR, DPR, CMDR and FSMR registers. It runs every byte-level
// command through a fixed-latency IDLE -> BUSY -> DONE engine and raises an
// interrupt on completion, so the wb driver, the predictor and the CMDR
// assertions can run without the real controller.
//
// Ports
//   clk_i   in   1           clock
//   rst_i   in   1           asynchronous active-high reset
//   cyc_i   in   1           bus cycle
//   stb_i   in   1           strobe
//   we_i    in   1           write enable
//   adr_i   in   ADDR_WIDTH  0 CSR, 1 DPR, 2 CMDR, 3 FSMR
//   dat_i   in   DATA_WIDTH  write data (bits [7:0] used)
//   dat_o   out  DATA_WIDTH  read data, valid while ack_o=1
//   ack_o   out  1           single-cycle acknowledge
//   irq_o   out  1           command-complete interrupt
// ----------------------------------------------------------------------------
module i2cmb_wb_responder #(
  parameter int         ADDR_WIDTH  = 2,
  parameter int         DATA_WIDTH  = 8,
  parameter int         NUM_BUSES   = 16,
  parameter int         CMD_LATENCY = 8,
  parameter logic [7:0] NAK_BYTE    = 8'hFF
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  cyc_i,
  input  logic                  stb_i,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] adr_i,
  input  logic [DATA_WIDTH-1:0] dat_i,
  output logic [DATA_WIDTH-1:0] dat_o,
  output logic                  ack_o,
  output logic                  irq_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int               CNT_W    = $clog2(CMD_LATENCY + 1);
  // BUSY is entered on the accept edge itself, so counting up to CMD_LATENCY
  // (not CMD_LATENCY-1) places DONE at accept + CMD_LATENCY + 1.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CMD_LATENCY);

  localparam logic [1:0] A_CSR  = 2'd0;
  localparam logic [1:0] A_DPR  = 2'd1;
  localparam logic [1:0] A_CMDR = 2'd2;
  localparam logic [1:0] A_FSMR = 2'd3;

  state_e                  state_q;
  logic [CNT_W-1:0]        cnt_q;
  logic                    e_q, ie_q, cap_q;
  logic [3:0]              bus_id_q;
  logic [7:0]              dpr_q, rd_cnt_q;
  logic                    don_q, nak_q, err_q;
  logic [2:0]              cmd_q;
  logic                    ack_q, irq_q, rd_cmdr_q;
  logic [DATA_WIDTH-1:0]   dat_q;
  logic [7:0]              rd_data_d;

  logic [1:0] adr;
  logic       req, wr, rd, abort, cmdr_rd_ack;

  assign adr   = adr_i[1:0];
  // A new request is only taken while ack_o is low, giving the two-cycle
  // minimum transfer and a single-cycle ack.
  assign req   = cyc_i & stb_i & ~ack_q;
  assign wr    = req & we_i;
  assign rd    = req & ~we_i;
  assign abort = wr && (adr == A_CSR) && !dat_i[7];
  // The ack cycle of a CMDR read: irq clears on the edge that ends it.
  assign cmdr_rd_ack = ack_q & rd_cmdr_q;

  assign dat_o = dat_q;
  assign ack_o = ack_q;
  assign irq_o = irq_q;

  // NOTE: every variable written in always_comb gets a default first so no
  // latch is inferred on paths that do not assign it.
  always_comb begin
    rd_data_d = 8'h00;
    case (adr)
      A_CSR:   rd_data_d = {e_q, ie_q, cap_q, cap_q, bus_id_q};
      A_DPR:   rd_data_d = dpr_q;
      A_CMDR:  rd_data_d = {don_q, nak_q, 1'b0, err_q, 1'b0, cmd_q};
      A_FSMR:  rd_data_d = {6'b0, state_q};
      default: rd_data_d = 8'h00;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only; where two
  // assignments to the same register land on one edge, the later one in this
  // block wins, which is how bus writes take priority over the engine below.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      e_q       <= 1'b0;
      ie_q      <= 1'b0;
      cap_q     <= 1'b0;
      bus_id_q  <= 4'h0;
      dpr_q     <= 8'h00;
      rd_cnt_q  <= 8'h00;
      don_q     <= 1'b1;
      nak_q     <= 1'b0;
      err_q     <= 1'b0;
      cmd_q     <= 3'b000;
      ack_q     <= 1'b0;
      irq_q     <= 1'b0;
      rd_cmdr_q <= 1'b0;
      dat_q     <= '0;
    end else begin
      ack_q     <= req;
      rd_cmdr_q <= rd && (adr == A_CMDR);
      if (rd) dat_q <= DATA_WIDTH'(rd_data_d);
      if (cmdr_rd_ack) irq_q <= 1'b0;

      // Command engine
      case (state_q)
        ST_BUSY: begin
          if (cnt_q == CNT_LAST) state_q <= ST_DONE;
          else                   cnt_q   <= cnt_q + CNT_W'(1);
        end
        ST_DONE: begin
          // A CMDR read ack in the DONE cycle holds DONE one more cycle, so
          // the irq clear and irq set never land on the same edge. An abort
          // discards the result entirely.
          if (!cmdr_rd_ack && !abort) begin
            state_q <= ST_IDLE;
            don_q   <= 1'b1;
            if (ie_q) irq_q <= 1'b1;
            case (cmd_q)
              3'b100: cap_q <= 1'b1;
              3'b101: cap_q <= 1'b0;
              3'b010: begin
                if (!cap_q)                 err_q <= 1'b1;
                else if (dpr_q == NAK_BYTE) nak_q <= 1'b1;
              end
              3'b000, 3'b001: begin
                if (!cap_q) err_q <= 1'b1;
                else begin
                  dpr_q    <= rd_cnt_q;
                  rd_cnt_q <= rd_cnt_q + 8'd1;
                end
              end
              3'b011: begin
                if (32'(dpr_q) < NUM_BUSES) bus_id_q <= dpr_q[3:0];
                else                        err_q    <= 1'b1;
              end
              3'b110:  ;
              default: err_q <= 1'b1;
            endcase
          end
        end
        default: ;
      endcase

      // Register writes, effective on the edge that raises ack_o
      if (wr) begin
        case (adr)
          A_CSR: begin
            e_q  <= dat_i[7];
            ie_q <= dat_i[6];
            if (abort) begin
              state_q <= ST_IDLE;
              cap_q   <= 1'b0;
              irq_q   <= 1'b0;
              don_q   <= 1'b1;
              nak_q   <= 1'b0;
              err_q   <= 1'b0;
              cmd_q   <= 3'b000;
            end
          end
          A_DPR: dpr_q <= dat_i[7:0];
          A_CMDR: begin
            if (e_q && (state_q == ST_IDLE)) begin
              cmd_q   <= dat_i[2:0];
              don_q   <= 1'b0;
              nak_q   <= 1'b0;
              err_q   <= 1'b0;
              cnt_q   <= '0;
              state_q <= ST_BUSY;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2cmb_wb_responder.sv
`timescale 1ns/1ps
// ----------------------------------------------------------------------------
// tb_i2cmb_wb_responder
//
// Directed bench for i2cmb_wb_responder. The master drives on the falling
// edge. The DUT samples on the rising edge. Outputs are read on the next
// falling edge.
// ----------------------------------------------------------------------------
module tb_i2cmb_wb_responder;

  logic       clk = 1'b0;
  logic       rst;
  logic       cyc, stb, we;
  logic [1:0] adr;
  logic [7:0] wdat;
  logic [7:0] rdat;
  logic       ack, irq;

  int tests = 0;
  int fails = 0;

  i2cmb_wb_responder dut (
    .clk_i (clk),
    .rst_i (rst),
    .cyc_i (cyc),
    .stb_i (stb),
    .we_i  (we),
    .adr_i (adr),
    .dat_i (wdat),
    .dat_o (rdat),
    .ack_o (ack),
    .irq_o (irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // One transfer. Returns at the falling edge of the ack cycle with the bus
  // released. Ack is expected exactly one cycle after the request.
  task automatic xfer(input logic w, input logic [1:0] a, input logic [7:0] d,
                      output logic [7:0] q);
    int n;
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; wdat = d;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ack && n < 8);
    check("ack_latency", n, 1);
    q = rdat;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    logic [7:0] unused;
    xfer(1'b1, a, d, unused);
  endtask

  task automatic rd_chk(input string tag, input logic [1:0] a, input logic [7:0] exp);
    logic [7:0] q;
    xfer(1'b0, a, 8'h00, q);
    check(tag, q, exp);
  endtask

  task automatic wait_cmd();
    repeat (12) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; adr = 2'd0; wdat = 8'h00;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Reset state
    check("rst_irq", irq, 0);
    check("rst_ack", ack, 0);
    check("rst_dat", rdat, 0);
    rd_chk("rst_cmdr", 2'd2, 8'h80);
    rd_chk("rst_csr",  2'd0, 8'h00);
    rd_chk("rst_fsmr", 2'd3, 8'h00);

    // Start: irq rises 10 cycles after the CMDR write ack
    wr(2'd0, 8'hC0);
    wr(2'd2, 8'h04);
    repeat (9) @(negedge clk);
    check("start_irq_early", irq, 0);
    @(negedge clk);
    check("start_irq_rise", irq, 1);
    rd_chk("start_cmdr", 2'd2, 8'h84);
    check("irq_hold_in_ack", irq, 1);
    @(negedge clk);
    check("irq_clear", irq, 0);
    rd_chk("start_csr", 2'd0, 8'hF0);

    // Write with NAK byte, then a normal write
    wr(2'd1, 8'hFF);
    wr(2'd2, 8'h02);
    wait_cmd();
    rd_chk("write_nak", 2'd2, 8'hC2);
    wr(2'd1, 8'h55);
    wr(2'd2, 8'h02);
    wait_cmd();
    rd_chk("write_ok", 2'd2, 8'h82);

    // Stop, then a Read without a captured bus
    wr(2'd2, 8'h05);
    wait_cmd();
    rd_chk("stop_cmdr", 2'd2, 8'h85);
    rd_chk("stop_csr", 2'd0, 8'hC0);
    wr(2'd2, 8'h00);
    wait_cmd();
    rd_chk("read_err", 2'd2, 8'h90);
    rd_chk("read_err_dpr", 2'd1, 8'h55);

    // Start, then two reads return the incrementing counter
    wr(2'd2, 8'h04);
    wait_cmd();
    rd_chk("restart", 2'd2, 8'h84);
    wr(2'd2, 8'h01);
    wait_cmd();
    rd_chk("read1_cmdr", 2'd2, 8'h81);
    rd_chk("read1_dpr", 2'd1, 8'h00);
    wr(2'd2, 8'h00);
    wait_cmd();
    rd_chk("read2_cmdr", 2'd2, 8'h80);
    rd_chk("read2_dpr", 2'd1, 8'h01);

    // Set bus: valid ID, then out-of-range ID
    wr(2'd1, 8'h05);
    wr(2'd2, 8'h03);
    wait_cmd();
    rd_chk("setbus_cmdr", 2'd2, 8'h83);
    rd_chk("setbus_csr", 2'd0, 8'hF5);
    wr(2'd1, 8'h10);
    wr(2'd2, 8'h03);
    wait_cmd();
    rd_chk("setbus_bad_cmdr", 2'd2, 8'h93);
    rd_chk("setbus_bad_csr", 2'd0, 8'hF5);

    // CMDR write while BUSY is ignored (the Stop must not land)
    wr(2'd2, 8'h06);
    wr(2'd2, 8'h05);
    rd_chk("busy_fsmr", 2'd3, 8'h01);
    wait_cmd();
    rd_chk("busy_ignore_cmdr", 2'd2, 8'h86);
    rd_chk("busy_ignore_csr", 2'd0, 8'hF5);
    check("pre_collide_irq", irq, 0);

    // CMDR read sampled on the edge DONE is entered (write edge w, read w+9)
    wr(2'd2, 8'h06);
    repeat (7) @(negedge clk);
    rd_chk("collide_cmdr", 2'd2, 8'h06);
    check("collide_irq_t", irq, 0);
    @(negedge clk);
    check("collide_irq_t1", irq, 0);
    @(negedge clk);
    check("collide_irq_t2", irq, 1);
    rd_chk("collide_after", 2'd2, 8'h86);

    // Abort mid-BUSY with E=0
    wr(2'd2, 8'h06);
    repeat (3) @(negedge clk);
    wr(2'd0, 8'h00);
    rd_chk("abort_fsmr", 2'd3, 8'h00);
    rd_chk("abort_cmdr", 2'd2, 8'h80);
    wait_cmd();
    check("abort_irq", irq, 0);
    rd_chk("abort_csr", 2'd0, 8'h05);

    // CMDR write with E=0 is ignored
    wr(2'd2, 8'h04);
    rd_chk("disabled_fsmr", 2'd3, 8'h00);
    rd_chk("disabled_cmdr", 2'd2, 8'h80);

    // Reset mid-BUSY
    wr(2'd0, 8'hC0);
    wr(2'd2, 8'h04);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    rd_chk("midrst_fsmr", 2'd3, 8'h00);
    rd_chk("midrst_cmdr", 2'd2, 8'h80);
    rd_chk("midrst_csr", 2'd0, 8'h00);
    wait_cmd();
    check("midrst_irq", irq, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
